// File: rtl/pkg_write.sv
// pkg_write: single-port ingress packet writer.
// Accepts one packet at a time as a word stream and stores it in 16-word MMU
// blocks taken from the free list. It writes one link-list entry per block:
// each non-last block points to the next block, and the last block holds the
// tail word count. When the packet ends it posts a descriptor
// {first block, full blocks - 1, drop}.
module pkg_write #(
    parameter int ADDR_LENTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRst,
    // ingress word stream
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iDataVld,
    input  logic                  iDataLast,
    output logic                  oDataRdy,
    // free-block list
    input  logic [ADDR_LENTH-1:0] iFreeAddr,
    input  logic                  iFreeAddrVld,
    output logic                  oFreeAddrRdy,
    // MMU block write port
    output logic [ADDR_LENTH-1:0] oBlockAddr,
    output logic [3:0]            oWordOfs,
    output logic [DATA_WIDTH-1:0] oMmuData,
    output logic                  oMmuWriteReq,
    output logic                  oMmuWriteLast,
    input  logic                  iMmuRdy,
    // link-list write port
    output logic [ADDR_LENTH-1:0] oLaddr,
    output logic [ADDR_LENTH-1:0] oLdata,
    output logic                  oLdataVld,
    // descriptor to the output queue
    output logic [ADDR_LENTH-1:0] oPkgFirAddr,
    output logic [3:0]            oPkgBlockNum,
    output logic                  oPkgDrop,
    output logic                  oPkgFirAddrVld,
    input  logic                  iPkgFirAddrRdy
);

    // 17 blocks hold at most 272 words. The word that would complete
    // block 17 is never written; an oversize packet switches to DISCARD at
    // 271 words, so the tail count of its last block stays nonzero.
    localparam logic [8:0] MAX_WORDS = 9'd271;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_WRITE,
        S_DISCARD,
        S_TAIL,
        S_DESC
    } state_t;

    state_t                state, state_nxt;
    logic [8:0]            word_cnt;    // words written to the MMU for this packet
    logic [3:0]            ofs;         // word offset inside the current block
    logic                  drop;        // packet overflowed and is being discarded
    logic                  is_first;    // the next pop is the packet's first block
    logic [ADDR_LENTH-1:0] cur_addr;    // block currently being filled
    logic [ADDR_LENTH-1:0] prev_addr;   // block that was just filled
    logic [ADDR_LENTH-1:0] first_addr;  // head of the chain, reported in the descriptor

    logic       pop;
    logic       beat;
    logic [8:0] cnt_nxt;
    logic [4:0] full_blocks_m1;

    assign pop     = (state == S_ALLOC) && iFreeAddrVld;
    assign beat    = (state == S_WRITE) && iDataVld && iMmuRdy;
    assign cnt_nxt = word_cnt + 9'd1;
    // A packet of W words has W/16 full blocks. The descriptor reports that
    // count minus one, truncated to 4 bits.
    assign full_blocks_m1 = word_cnt[8:4] - 5'd1;

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Per-packet datapath: word and offset counters, block addresses, drop flag
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            word_cnt   <= '0;
            ofs        <= '0;
            drop       <= 1'b0;
            is_first   <= 1'b0;
            cur_addr   <= '0;
            prev_addr  <= '0;
            first_addr <= '0;
        end else begin
            if (state == S_IDLE && iDataVld) begin
                word_cnt <= '0;
                drop     <= 1'b0;
                is_first <= 1'b1;
            end
            if (pop) begin
                cur_addr <= iFreeAddr;
                ofs      <= '0;
                is_first <= 1'b0;
                if (is_first) first_addr <= iFreeAddr;
            end
            if (beat) begin
                word_cnt <= cnt_nxt;
                ofs      <= ofs + 4'd1;
                if (!iDataLast) begin
                    if (ofs == 4'hF)
                        prev_addr <= cur_addr;
                    else if (cnt_nxt == MAX_WORDS)
                        drop <= 1'b1;
                end
            end
        end
    end

    // Next state and all outputs. Every output is zero outside the state that
    // drives it, so a reset clears all outputs in the same cycle.
    always_comb begin
        state_nxt      = state;
        oDataRdy       = 1'b0;
        oFreeAddrRdy   = 1'b0;
        oBlockAddr     = '0;
        oWordOfs       = '0;
        oMmuData       = '0;
        oMmuWriteReq   = 1'b0;
        oMmuWriteLast  = 1'b0;
        oLaddr         = '0;
        oLdata         = '0;
        oLdataVld      = 1'b0;
        oPkgFirAddr    = '0;
        oPkgBlockNum   = '0;
        oPkgDrop       = 1'b0;
        oPkgFirAddrVld = 1'b0;
        case (state)
            S_IDLE: begin
                if (iDataVld) state_nxt = S_ALLOC;
            end
            S_ALLOC: begin
                // Ingress is stalled until the free list can supply a block.
                // Every block after the first is linked from its predecessor
                // in the pop cycle, before any data reaches it.
                oFreeAddrRdy = iFreeAddrVld;
                if (iFreeAddrVld) begin
                    state_nxt = S_WRITE;
                    if (!is_first) begin
                        oLaddr    = prev_addr;
                        oLdata    = iFreeAddr;
                        oLdataVld = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                oDataRdy      = iMmuRdy;
                oMmuWriteReq  = iDataVld;
                oMmuData      = iData;
                oBlockAddr    = cur_addr;
                oWordOfs      = ofs;
                oMmuWriteLast = iDataVld && (ofs == 4'hF || iDataLast);
                if (beat) begin
                    if (iDataLast)              state_nxt = S_TAIL;
                    else if (ofs == 4'hF)       state_nxt = S_ALLOC;
                    else if (cnt_nxt == MAX_WORDS) state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // Swallow the rest of an oversize packet without writing it.
                oDataRdy = 1'b1;
                if (iDataVld && iDataLast) state_nxt = S_TAIL;
            end
            S_TAIL: begin
                // The last block links to its word count. The count is 0 when
                // the packet ends exactly on a block boundary.
                oLaddr    = cur_addr;
                oLdata    = {{(ADDR_LENTH-4){1'b0}}, word_cnt[3:0]};
                oLdataVld = 1'b1;
                state_nxt = S_DESC;
            end
            S_DESC: begin
                oPkgFirAddrVld = 1'b1;
                oPkgFirAddr    = first_addr;
                oPkgBlockNum   = (word_cnt[8:4] == 5'd0) ? 4'd0 : full_blocks_m1[3:0];
                // A runt with no full block is always dropped.
                oPkgDrop       = drop || (word_cnt[8:4] == 5'd0);
                if (iPkgFirAddrRdy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pkg_write.sv
// Scoreboard bench for pkg_write. Stimulus pushes the expected MMU writes,
// link entries and descriptor of each packet into queues. A negedge monitor
// pops and compares them whenever the DUT presents a handshake.
module tb_pkg_write;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic [DW-1:0] iData = '0;
    logic          iDataVld = 1'b0, iDataLast = 1'b0, oDataRdy;
    logic [AW-1:0] iFreeAddr = '0;
    logic          iFreeAddrVld = 1'b0, oFreeAddrRdy;
    logic [AW-1:0] oBlockAddr;
    logic [3:0]    oWordOfs;
    logic [DW-1:0] oMmuData;
    logic          oMmuWriteReq, oMmuWriteLast;
    logic          iMmuRdy = 1'b1;
    logic [AW-1:0] oLaddr, oLdata;
    logic          oLdataVld;
    logic [AW-1:0] oPkgFirAddr;
    logic [3:0]    oPkgBlockNum;
    logic          oPkgDrop, oPkgFirAddrVld;
    logic          iPkgFirAddrRdy = 1'b1;

    pkg_write #(.ADDR_LENTH(AW), .DATA_WIDTH(DW)) dut (
        .iClk(iClk), .iRst(iRst),
        .iData(iData), .iDataVld(iDataVld), .iDataLast(iDataLast), .oDataRdy(oDataRdy),
        .iFreeAddr(iFreeAddr), .iFreeAddrVld(iFreeAddrVld), .oFreeAddrRdy(oFreeAddrRdy),
        .oBlockAddr(oBlockAddr), .oWordOfs(oWordOfs), .oMmuData(oMmuData),
        .oMmuWriteReq(oMmuWriteReq), .oMmuWriteLast(oMmuWriteLast), .iMmuRdy(iMmuRdy),
        .oLaddr(oLaddr), .oLdata(oLdata), .oLdataVld(oLdataVld),
        .oPkgFirAddr(oPkgFirAddr), .oPkgBlockNum(oPkgBlockNum), .oPkgDrop(oPkgDrop),
        .oPkgFirAddrVld(oPkgFirAddrVld), .iPkgFirAddrRdy(iPkgFirAddrRdy)
    );

    always #5 iClk = ~iClk;

    typedef struct packed { logic [AW-1:0] addr; logic [3:0] ofs; logic [DW-1:0] data; logic last; } wr_t;
    typedef struct packed { logic [AW-1:0] laddr; logic [AW-1:0] ldata; logic tail; } link_t;
    typedef struct packed { logic [AW-1:0] first; logic [3:0] num; logic drop; } desc_t;

    wr_t           exp_wr[$];
    link_t         exp_link[$];
    desc_t         exp_desc[$];
    logic [AW-1:0] free_q[$];

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    last_acc_cyc = 0;
    int    tail_cyc = 0;
    int    wr_count = 0;
    int    link_count = 0;
    bit    desc_seen = 0;
    desc_t desc_held, last_desc;

    bit mmu_rand = 0;
    int desc_delay = 0;
    bit free_stall_mode = 0;

    always @(posedge iClk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT event with no expectation queued (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every MMU write, link write and descriptor against the scoreboard
    always @(negedge iClk) begin
        if (!iRst) begin
            if (iDataVld && oDataRdy && iDataLast) last_acc_cyc = cyc;
            if (oMmuWriteReq && iMmuRdy) begin
                wr_count++;
                if (exp_wr.size() == 0) unexpected("mmu_write");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("mmu_write{addr,ofs,data,last}",
                          {oBlockAddr, oWordOfs, oMmuData, oMmuWriteLast}, e);
                end
            end
            if (oLdataVld) begin
                link_count++;
                if (exp_link.size() == 0) unexpected("link_write");
                else begin
                    link_t l;
                    l = exp_link.pop_front();
                    check("link_write{laddr,ldata}", {oLaddr, oLdata}, {l.laddr, l.ldata});
                    if (l.tail) begin
                        check("tail_latency", cyc, last_acc_cyc + 1);
                        tail_cyc = cyc;
                    end
                end
            end
            if (oPkgFirAddrVld) begin
                if (!desc_seen) begin
                    desc_seen = 1;
                    desc_held = {oPkgFirAddr, oPkgBlockNum, oPkgDrop};
                    check("desc_latency", cyc, tail_cyc + 1);
                end else
                    check("desc_stable", {oPkgFirAddr, oPkgBlockNum, oPkgDrop}, desc_held);
                if (iPkgFirAddrRdy) begin
                    desc_seen = 0;
                    last_desc = {oPkgFirAddr, oPkgBlockNum, oPkgDrop};
                    if (exp_desc.size() == 0) unexpected("descriptor");
                    else check("descriptor{first,num,drop}",
                               {oPkgFirAddr, oPkgBlockNum, oPkgDrop}, exp_desc.pop_front());
                end
            end
        end
    end

    // MMU ready: always high or random per cycle
    initial forever begin
        @(posedge iClk); #1;
        iMmuRdy = mmu_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output-queue ready: immediate, or raised after desc_delay cycles of valid
    initial begin
        int hold = 0;
        forever begin
            @(negedge iClk);
            if (oPkgFirAddrVld && !iPkgFirAddrRdy) hold++;
            else hold = 0;
            @(posedge iClk); #1;
            iPkgFirAddrRdy = (desc_delay == 0) || (hold >= desc_delay);
        end
    end

    // Free list: presents the head of free_q. In stall mode it is empty for
    // 20 cycles after every pop, so each block boundary waits on it.
    initial begin
        bit take;
        int stall = 0;
        forever begin
            @(negedge iClk);
            take = oFreeAddrRdy && iFreeAddrVld && !iRst;
            @(posedge iClk); #1;
            if (take && free_q.size() > 0) begin
                void'(free_q.pop_front());
                if (free_stall_mode) stall = 20;
            end else if (stall > 0) stall--;
            if (iRst) stall = 0;
            iFreeAddrVld = (free_q.size() > 0) && (stall == 0);
            iFreeAddr    = (free_q.size() > 0) ? free_q[0] : '0;
        end
    end

    // Drive n words (base+i), holding each one until it is accepted
    task automatic send_words(input int n, input logic [DW-1:0] base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int bound;
            iData     = base + DW'(i);
            iDataVld  = 1'b1;
            iDataLast = with_last && (i == n - 1);
            acc   = 0;
            bound = 0;
            while (!acc) begin
                @(negedge iClk);
                acc = oDataRdy;
                bound++;
                @(posedge iClk); #1;
                if (!acc && bound > 2000) begin
                    unexpected("data_accept_timeout");
                    iDataVld  = 1'b0;
                    iDataLast = 1'b0;
                    return;
                end
            end
        end
        iDataVld  = 1'b0;
        iDataLast = 1'b0;
    endtask

    // Queue a packet's free blocks and expectations, send it, and wait for its descriptor
    task automatic run_pkt(input int n, input logic [DW-1:0] base, input logic [AW-1:0] a0);
        int w, nblk, t;
        w    = (n > 271) ? 271 : n;
        nblk = (w + 15) / 16;
        for (int k = 0; k < nblk; k++) free_q.push_back(a0 + AW'(k));
        for (int i = 0; i < w; i++)
            exp_wr.push_back({a0 + AW'(i / 16), 4'(i % 16), base + DW'(i),
                              1'((i % 16 == 15) || (i == n - 1))});
        for (int k = 0; k < nblk - 1; k++)
            exp_link.push_back({a0 + AW'(k), a0 + AW'(k + 1), 1'b0});
        exp_link.push_back({a0 + AW'(nblk - 1), AW'(w % 16), 1'b1});
        exp_desc.push_back({a0, (w < 16) ? 4'd0 : 4'(w / 16 - 1), 1'((n > 271) || (w < 16))});
        send_words(n, base, 1'b1);
        t = 0;
        while (exp_desc.size() > 0 && t < 3000) begin
            @(posedge iClk); #1;
            t++;
        end
        if (exp_desc.size() > 0) unexpected("descriptor_timeout");
        check("writes_drained", exp_wr.size(), 0);
        check("links_drained", exp_link.size(), 0);
        check("blocks_popped", free_q.size(), 0);
        @(posedge iClk); #1;
    endtask

    initial begin
        int w0, l0;
        // reset state: all outputs 0 even with ingress valid
        iDataVld = 1'b1;
        iData    = 32'hDEAD_BEEF;
        #12;
        check("reset_outputs",
              {oDataRdy, oFreeAddrRdy, oBlockAddr, oWordOfs, oMmuData, oMmuWriteReq, oMmuWriteLast,
               oLaddr, oLdata, oLdataVld, oPkgFirAddr, oPkgBlockNum, oPkgDrop, oPkgFirAddrVld}, 0);
        iDataVld = 1'b0;
        iData    = '0;
        @(posedge iClk); #1;
        iRst = 1'b0;
        @(posedge iClk); #1;

        // 64 words, blocks 5..8: chain 5->6->7->8->0, descriptor {5,3,0}
        w0 = wr_count; l0 = link_count;
        run_pkt(64, 32'h1000_0000, 12'd5);
        check("p64_writes", wr_count - w0, 64);
        check("p64_links", link_count - l0, 4);
        check("p64_desc", last_desc, {12'd5, 4'd3, 1'b0});

        // 18 words, blocks 10,11: chain 10->11->2, descriptor {10,0,0}
        w0 = wr_count; l0 = link_count;
        run_pkt(18, 32'h2000_0000, 12'd10);
        check("p18_writes", wr_count - w0, 18);
        check("p18_links", link_count - l0, 2);
        check("p18_desc", last_desc, {12'd10, 4'd0, 1'b0});

        // 10-word runt in block 3: link 3->10, descriptor {3,0,1}
        w0 = wr_count; l0 = link_count;
        run_pkt(10, 32'h3000_0000, 12'd3);
        check("p10_writes", wr_count - w0, 10);
        check("p10_links", link_count - l0, 1);
        check("p10_desc", last_desc, {12'd3, 4'd0, 1'b1});

        // 300 words: 17 blocks, 271 writes, 29 swallowed, tail 15, {100,15,1}
        w0 = wr_count; l0 = link_count;
        run_pkt(300, 32'h4000_0000, 12'd100);
        check("p300_writes", wr_count - w0, 271);
        check("p300_links", link_count - l0, 17);
        check("p300_desc", last_desc, {12'd100, 4'd15, 1'b1});

        // Exactly 256 words: the packet ends on a block boundary, tail 0, {200,15,0}
        run_pkt(256, 32'h5000_0000, 12'd200);
        check("p256_desc", last_desc, {12'd200, 4'd15, 1'b0});

        // Backpressure: random MMU ready, free list empty 20 cycles per boundary, queue delayed 7
        mmu_rand = 1; free_stall_mode = 1; desc_delay = 7;
        run_pkt(40, 32'h6000_0000, 12'd300);
        check("stall_desc", last_desc, {12'd300, 4'd1, 1'b0});
        free_stall_mode = 0;

        // Random-length packets with random readiness
        for (int p = 0; p < 100; p++) begin
            desc_delay = (p % 3 == 0) ? 7 : 0;
            run_pkt($urandom_range(1, 300), {8'(p), 24'h0}, AW'($urandom_range(0, 3800)));
        end

        // Reset mid-WRITE: outputs drop at once; the next packet starts clean
        mmu_rand = 0; desc_delay = 0;
        free_q.push_back(12'd77);
        for (int i = 0; i < 5; i++) exp_wr.push_back({12'd77, 4'(i), 32'h7000_0000 + 32'(i), 1'b0});
        send_words(5, 32'h7000_0000, 1'b0);
        iData    = 32'h7000_0005;
        iDataVld = 1'b1;
        #2;
        check("pre_reset_write_req", oMmuWriteReq, 1'b1);
        iRst = 1'b1;
        #1;
        check("midreset_outputs",
              {oDataRdy, oFreeAddrRdy, oBlockAddr, oWordOfs, oMmuData, oMmuWriteReq, oMmuWriteLast,
               oLaddr, oLdata, oLdataVld, oPkgFirAddr, oPkgBlockNum, oPkgDrop, oPkgFirAddrVld}, 0);
        check("prereset_writes_seen", exp_wr.size(), 0);
        iDataVld = 1'b0;
        free_q.delete();
        exp_wr.delete(); exp_link.delete(); exp_desc.delete();
        desc_seen = 0;
        @(posedge iClk); @(posedge iClk); #1;
        iRst = 1'b0;
        @(posedge iClk); #1;
        run_pkt(20, 32'h8000_0000, 12'd900);
        check("post_reset_desc", last_desc, {12'd900, 4'd0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pkg_write.md
# pkg_write

Single-port packet writer: the ingress-side counterpart of the packet reader. It accepts one Ethernet packet at a time as a 32-bit word stream and allocates 16-word blocks from the free-block list. It writes the words into MMU block memory and builds the per-block link-list chain. When the packet ends it emits a descriptor (first block address, full-block count, drop flag) to the output queue, which the reader later consumes.

## Interface
- ADDR_LENTH, 12, block address width
- DATA_WIDTH, 32, data word width
- iClk  in  1  clock; all logic on rising edge
- iRst  in  1  asynchronous, active-high reset
- iData  in  DATA_WIDTH  ingress packet word
- iDataVld  in  1  ingress word valid
- iDataLast  in  1  qualifies final word of packet
- oDataRdy  out  1  ingress ready
- iFreeAddr  in  ADDR_LENTH  free block address
- iFreeAddrVld  in  1  free list non-empty
- oFreeAddrRdy  out  1  pop free list (1-cycle pulse per block)
- oBlockAddr  out  ADDR_LENTH  MMU target block
- oWordOfs  out  4  word offset inside block
- oMmuData  out  DATA_WIDTH  MMU write data
- oMmuWriteReq  out  1  MMU write request
- oMmuWriteLast  out  1  current write is offset 15 or packet last
- iMmuRdy  in  1  MMU accepts write
- oLaddr  out  ADDR_LENTH  link-list entry address
- oLdata  out  ADDR_LENTH  link-list entry data
- oLdataVld  out  1  link-list write strobe
- oPkgFirAddr  out  ADDR_LENTH  descriptor: first block
- oPkgBlockNum  out  4  descriptor: full blocks − 1
- oPkgDrop  out  1  descriptor: packet to be discarded
- oPkgFirAddrVld  out  1  descriptor valid
- iPkgFirAddrRdy  in  1  descriptor accepted

## Operation
- States: IDLE, ALLOC, WRITE, DISCARD, TAIL, DESC.
- IDLE: oDataRdy=0; on iDataVld → ALLOC; clear 9-bit word counter W and drop flag.
- ALLOC: oFreeAddrRdy=iFreeAddrVld. On pop: rCur←iFreeAddr, offset←0. First block: rFirst←iFreeAddr. Otherwise, in the same cycle, write link entry oLaddr=rPrev, oLdata=iFreeAddr, oLdataVld=1. → WRITE. Stays in ALLOC while the free list is empty; ingress stalled.
- WRITE: oMmuWriteReq=iDataVld, oDataRdy=iMmuRdy, oMmuData=iData, oBlockAddr=rCur, oWordOfs=offset (combinational pass-through). Beat = iDataVld&iMmuRdy. Each beat: W++, offset++.
  - Beat with iDataLast → TAIL.
  - Else beat at offset 15 → rPrev←rCur, ALLOC.
  - Else beat making W=271 → drop←1, DISCARD.
- DISCARD: oDataRdy=1, no MMU writes; beat with iDataLast → TAIL.
- TAIL: one-cycle link write oLaddr=rCur, oLdata=W[3:0] (tail word count; 0 when packet ends on block boundary, zero-extended). → DESC.
- DESC: oPkgFirAddrVld=1, oPkgFirAddr=rFirst, oPkgBlockNum=(W>>4)−1 (4-bit), oPkgDrop=drop | (W<16). For W<16, oPkgBlockNum=0. Hold until iPkgFirAddrRdy, then → IDLE.
- Chain invariant: blocks allocated = ceil(W/16), max 17; every non-last block links to the next; the last block links to the tail count. The reader's link reads = blockNum+1 (+1 if tail≠0).
- Dropped packets keep their chain; the reader returns the blocks via its drop path.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-packet aborts immediately; allocated blocks are not recovered (free list reinitialised by the same reset).
- First MMU write no earlier than 2 cycles after the first iDataVld (IDLE, ALLOC).
- One bubble cycle (ALLOC) per 16-word block boundary when the free list is non-empty.
- Last beat → TAIL link write next cycle → descriptor valid the cycle after.
- Link write for block k+1 occurs in the pop cycle of block k+1, never later than the first data write to that block.
- oLdataVld and oFreeAddrRdy are never high in DESC/IDLE. oMmuWriteReq is never high outside WRITE.
- iDataVld/iData must hold until accepted; oDataRdy may toggle with iMmuRdy.

## Test plan
- 64-word packet, free addrs 5,6,7,8, MMU/queue always ready → links 5→6, 6→7, 7→8, 8→0; descriptor {5, blockNum 3, drop 0}; 64 writes, oMmuWriteLast at offsets 15.
- 18-word packet, free 10,11 → links 10→11, 11→2; descriptor {10, 0, 0}; writes to 11 only at offsets 0–1.
- 10-word runt, free 3 → link 3→10; descriptor {3, 0, drop 1}.
- 300-word packet → 17 blocks popped, 271 MMU writes, 29 words swallowed in DISCARD, last link tail 15, descriptor blockNum 15, drop 1.
- Random iMmuRdy, free list empty for 20 cycles at the block boundary, iPkgFirAddrRdy delayed 7 cycles → no data loss or duplication, descriptor held stable until accepted; 100 back-to-back random packets match the reader's expected counts.
- iRst asserted mid-WRITE → all outputs 0 the same cycle; next packet starts from IDLE with a fresh first address.
